// File: rtl/branch_history_table_pkg.sv
// Shared types and defaults for the frontend branch history table.
package branch_history_table_pkg;

    // Default table size taken from the core configuration.
    localparam int unsigned BHT_ENTRIES  = 128;
    // PCs are halfword aligned, so bit 0 never selects an entry.
    localparam int unsigned BHT_OFFSET   = 1;
    localparam int unsigned BHT_PKG_VLEN = 64;

    // Resolved branch coming back from execute.
    typedef struct packed {
        logic                    valid;
        logic [BHT_PKG_VLEN-1:0] pc;
        logic                    taken;
    } bht_update_t;

    // Per-slot prediction handed to the realigner.
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // One stored entry: trained flag plus 2-bit saturating counter.
    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_entry_t;

endpackage

// File: rtl/branch_history_table_sat_counter.sv
// 2-bit saturating counter step: first training seeds weakly taken /
// weakly not-taken, later training moves one step and saturates.
module sat_counter_2b (
    input  logic       valid_i,
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic       valid_o,
    output logic [1:0] cnt_o
);

    // Next counter value for one resolved branch.
    always_comb begin
        valid_o = 1'b1;
        cnt_o   = cnt_i;
        if (!valid_i) begin
            cnt_o = taken_i ? 2'b10 : 2'b01;
        end else if (taken_i) begin
            if (cnt_i != 2'b11) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != 2'b00) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: flop array of 2-bit counters, read combinationally
// by fetch PC and trained by resolved branches. No tags, so aliasing PCs
// share an entry.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned NR_ENTRIES      = BHT_ENTRIES,
    parameter int unsigned INSTR_PER_FETCH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [VLEN-1:0]            vpc_i,
    input  logic                       bht_update_valid_i,
    input  logic [VLEN-1:0]            bht_update_pc_i,
    input  logic                       bht_update_taken_i,
    output logic [INSTR_PER_FETCH-1:0] bht_prediction_valid_o,
    output logic [INSTR_PER_FETCH-1:0] bht_prediction_taken_o
);

    localparam int unsigned OFFSET        = BHT_OFFSET;
    localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned INDEX_BITS    = $clog2(NR_ROWS);
    // Keep a 1-bit slot select even with a single slot per row.
    localparam int unsigned SLOT_W        = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;

    bht_entry_t [NR_ROWS-1:0][INSTR_PER_FETCH-1:0] bht_d, bht_q;

    logic [INDEX_BITS-1:0] rd_row;
    logic [INDEX_BITS-1:0] upd_row;
    logic [SLOT_W-1:0]     upd_slot;
    logic                  upd_en;
    bht_entry_t            upd_old;
    bht_entry_t            upd_new;

    bht_prediction_t [INSTR_PER_FETCH-1:0] pred;

    // Only the index/slot bits select an entry; the rest of each PC is
    // intentionally ignored (this is what allows aliasing).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{vpc_i, bht_update_pc_i};

    assign rd_row  = vpc_i[OFFSET+ROW_ADDR_BITS +: INDEX_BITS];
    assign upd_row = bht_update_pc_i[OFFSET+ROW_ADDR_BITS +: INDEX_BITS];

    generate
        if (ROW_ADDR_BITS == 0) begin : g_single_slot
            assign upd_slot = '0;
        end else begin : g_multi_slot
            assign upd_slot = bht_update_pc_i[OFFSET +: ROW_ADDR_BITS];
        end
    endgenerate

    // Training is frozen in debug mode and overridden by a flush.
    assign upd_en  = bht_update_valid_i && !debug_mode_i && !flush_i;
    assign upd_old = bht_q[upd_row][upd_slot];

    // Single counter step shared by whichever entry is being trained.
    sat_counter_2b i_sat_counter (
        .valid_i (upd_old.valid),
        .cnt_i   (upd_old.cnt),
        .taken_i (bht_update_taken_i),
        .valid_o (upd_new.valid),
        .cnt_o   (upd_new.cnt)
    );

    // Per-slot combinational read of the addressed row; no bypass of a
    // same-cycle update.
    generate
        for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_read
            assign pred[i].valid             = bht_q[rd_row][i].valid;
            assign pred[i].taken             = bht_q[rd_row][i].cnt[1];
            assign bht_prediction_valid_o[i] = pred[i].valid;
            assign bht_prediction_taken_o[i] = pred[i].taken;
        end
    endgenerate

    // Next table state: flush clears everything, otherwise write at most one entry.
    always_comb begin
        bht_d = bht_q;
        if (flush_i) begin
            bht_d = '0;
        end else if (upd_en) begin
            bht_d[upd_row][upd_slot] = upd_new;
        end
    end

    // Table storage with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bht_q <= '0;
        end else begin
            bht_q <= bht_d;
        end
    end

endmodule
